// File: rtl/calc_operand_entry.sv
// Keypad front end: turns key codes into a signed operand pair, opcode and newop strobe.
// Optional result chaining (operator after '=' reuses answer) is enabled by defining CALC_CHAIN_EN.
module calc_operand_entry #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] answer,
  output logic [15:0] V1,
  output logic [15:0] V2,
  output logic [1:0]  opcode,
  output logic        newop,
  output logic [15:0] entry_value,
  output logic        entry_ovf,
  output logic [1:0]  state_dbg
);

  // Key interface: key_valid is a one-cycle strobe with no back-pressure;
  // every key presented with key_valid=1 is consumed in that same cycle.

  localparam logic [1:0] S_FIRST  = 2'd0;
  localparam logic [1:0] S_OPER   = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [3:0] KEY_EQUALS = 4'd13;
  localparam logic [3:0] KEY_CLEAR  = 4'd14;
  localparam logic [3:0] KEY_NEGATE = 4'd15;

  logic [1:0]  state;
  logic [1:0]  op_reg;
  logic [14:0] mag;
  logic        neg;
  logic [2:0]  count;

  logic [18:0] new_mag;
  logic        is_digit;
  logic        is_oper;
  logic        digit_ok;
  logic [3:0]  op_off;
  logic [1:0]  op_in;
  logic [15:0] signed_val;

  // 19-bit intermediate holds 32767*10+9 without wrapping
  assign new_mag    = ({4'd0, mag} * 19'd10) + {15'd0, key_code};
  assign is_digit   = (key_code <= 4'd9);
  assign is_oper    = (key_code == 4'd10) || (key_code == 4'd11) || (key_code == 4'd12);
  assign digit_ok   = (count < 3'(MAX_DIGITS)) && (new_mag <= 19'd32767);
  assign op_off     = key_code - 4'd10;
  assign op_in      = op_off[1:0];
  assign signed_val = neg ? (16'd0 - {1'b0, mag}) : {1'b0, mag};

  assign entry_value = signed_val;
  assign state_dbg   = state;

`ifndef CALC_CHAIN_EN
  logic unused_answer;
  assign unused_answer = ^answer;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FIRST;
      op_reg    <= 2'b00;
      mag       <= 15'd0;
      neg       <= 1'b0;
      count     <= 3'd0;
      V1        <= 16'd0;
      V2        <= 16'd0;
      opcode    <= 2'b00;
      newop     <= 1'b0;
      entry_ovf <= 1'b0;
    end else begin
      newop <= 1'b0;
      if (key_valid) begin
        if (key_code == KEY_CLEAR) begin
          state     <= S_FIRST;
          op_reg    <= 2'b00;
          mag       <= 15'd0;
          neg       <= 1'b0;
          count     <= 3'd0;
          V1        <= 16'd0;
          V2        <= 16'd0;
          opcode    <= 2'b00;
          entry_ovf <= 1'b0;
        end else begin
          case (state)
            S_FIRST, S_SECOND: begin
              if (is_digit) begin
                if (digit_ok) begin
                  mag   <= new_mag[14:0];
                  count <= count + 3'd1;
                end else begin
                  entry_ovf <= 1'b1;
                end
              end else if (key_code == KEY_NEGATE) begin
                neg <= ~neg;
              end else if (is_oper && state == S_FIRST) begin
                V2        <= signed_val;
                op_reg    <= op_in;
                mag       <= 15'd0;
                neg       <= 1'b0;
                count     <= 3'd0;
                entry_ovf <= 1'b0;
                state     <= S_OPER;
              end else if (key_code == KEY_EQUALS && state == S_SECOND) begin
                V1     <= signed_val;
                opcode <= op_reg;
                newop  <= 1'b1;
                state  <= S_RESULT;
              end
            end
            S_OPER: begin
              if (is_digit) begin
                mag   <= {11'd0, key_code};
                count <= 3'd1;
                state <= S_SECOND;
              end else if (is_oper) begin
                op_reg <= op_in;
              end
            end
            S_RESULT: begin
              // a digit after '=' starts a fresh first operand
              if (is_digit) begin
                mag       <= {11'd0, key_code};
                count     <= 3'd1;
                neg       <= 1'b0;
                entry_ovf <= 1'b0;
                state     <= S_FIRST;
              end
`ifdef CALC_CHAIN_EN
              else if (is_oper) begin
                V2     <= answer;
                op_reg <= op_in;
                mag    <= 15'd0;
                neg    <= 1'b0;
                count  <= 3'd0;
                state  <= S_OPER;
              end
`endif
            end
            default: state <= S_FIRST;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Self-checking bench for calc_operand_entry: directed keypad sequences plus random keys vs a model.
module tb_calc_operand_entry;

  localparam int MAX_DIGITS = 5;
  localparam int K_ADD = 10, K_MUL = 11, K_SUB = 12, K_EQ = 13, K_CLR = 14, K_NEG = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] answer;
  logic [15:0] V1, V2, entry_value;
  logic [1:0]  opcode, state_dbg;
  logic        newop, entry_ovf;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  calc_operand_entry #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .answer(answer), .V1(V1), .V2(V2), .opcode(opcode), .newop(newop),
    .entry_value(entry_value), .entry_ovf(entry_ovf), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // phase: 0 typing first operand, 1 operator just chosen, 2 typing second, 3 result shown
  int          m_phase, m_mag, m_cnt;
  bit          m_neg, m_ovf, m_newop;
  logic [15:0] m_v1, m_v2;
  logic [1:0]  m_opcode, m_opreg;

  function automatic logic [15:0] as_signed(input int mag, input bit neg);
    int v;
    v = neg ? -mag : mag;
    return v[15:0];
  endfunction

  always @(posedge clock) begin
    int k;
    m_newop = 0;
    if (reset) begin
      m_phase = 0; m_mag = 0; m_cnt = 0; m_neg = 0; m_ovf = 0;
      m_v1 = 0; m_v2 = 0; m_opcode = 0; m_opreg = 0;
    end else if (key_valid) begin
      k = int'(key_code);
      if (k == K_CLR) begin
        m_phase = 0; m_mag = 0; m_cnt = 0; m_neg = 0; m_ovf = 0;
        m_v1 = 0; m_v2 = 0; m_opcode = 0;
      end else if (k <= 9) begin
        if (m_phase == 0 || m_phase == 2) begin
          if (m_cnt < MAX_DIGITS && m_mag * 10 + k <= 32767) begin
            m_mag = m_mag * 10 + k; m_cnt++;
          end else m_ovf = 1;
        end else begin
          if (m_phase == 3) begin m_neg = 0; m_ovf = 0; end
          m_mag = k; m_cnt = 1;
          m_phase = (m_phase == 1) ? 2 : 0;
        end
      end else if (k == K_NEG) begin
        if (m_phase == 0 || m_phase == 2) m_neg = !m_neg;
      end else if (k == K_EQ) begin
        if (m_phase == 2) begin
          m_v1 = as_signed(m_mag, m_neg); m_opcode = m_opreg; m_newop = 1; m_phase = 3;
        end
      end else begin
        if (m_phase == 0) begin
          m_v2 = as_signed(m_mag, m_neg); m_opreg = 2'(k - 10);
          m_mag = 0; m_neg = 0; m_cnt = 0; m_ovf = 0; m_phase = 1;
        end else if (m_phase == 1) begin
          m_opreg = 2'(k - 10);
        end
`ifdef CALC_CHAIN_EN
        else if (m_phase == 3) begin
          m_v2 = answer; m_opreg = 2'(k - 10);
          m_mag = 0; m_neg = 0; m_cnt = 0; m_phase = 1;
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle after reset the outputs must match the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("V1", V1, m_v1);
      check("V2", V2, m_v2);
      check("opcode", {14'd0, opcode}, {14'd0, m_opcode});
      check("newop", {15'd0, newop}, {15'd0, m_newop});
      check("entry_value", entry_value, as_signed(m_mag, m_neg));
      check("entry_ovf", {15'd0, entry_ovf}, {15'd0, m_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; answer = 16'd0;
    repeat (2) @(negedge clock);
    check("rst_V1", V1, 16'd0);
    check("rst_V2", V2, 16'd0);
    check("rst_entry", entry_value, 16'd0);
    check("rst_newop", {15'd0, newop}, 16'd0);
    check("rst_ovf", {15'd0, entry_ovf}, 16'd0);
    reset = 1'b0;
    chk_en = 1;

    // 12 + 34
    press(1); press(2); press(K_ADD); press(3); press(4); press(K_EQ);
    check("t1_newop_hi", {15'd0, newop}, 16'd1);
    check("t1_V2", V2, 16'd12);
    check("t1_V1", V1, 16'd34);
    check("t1_opcode", {14'd0, opcode}, 16'd0);
    idle(1);
    check("t1_newop_lo", {15'd0, newop}, 16'd0);

    // 50 - 7, then a repeated '=' must not pulse again
    press(5); press(0); press(K_SUB); press(7); press(K_EQ);
    check("t2_V2", V2, 16'd50);
    check("t2_V1", V1, 16'd7);
    check("t2_opcode", {14'd0, opcode}, 16'd2);
    press(K_EQ);
    check("t2_no_newop", {15'd0, newop}, 16'd0);
    check("t2_V1_hold", V1, 16'd7);

    // digit limits
    press(K_CLR); press(3); press(2); press(7); press(6); press(7);
    check("t3_max", entry_value, 16'd32767);
    check("t3_ovf0", {15'd0, entry_ovf}, 16'd0);
    press(8);
    check("t3_max_hold", entry_value, 16'd32767);
    check("t3_ovf1", {15'd0, entry_ovf}, 16'd1);
    press(K_CLR); press(4); press(0); press(0); press(0); press(0);
    check("t3_4000", entry_value, 16'd4000);
    check("t3_ovf_mag", {15'd0, entry_ovf}, 16'd1);

    // negatives and operator replacement
    press(K_CLR); press(9); press(K_NEG); press(K_MUL); press(K_ADD);
    press(3); press(K_NEG); press(K_EQ);
    check("t4_V2", V2, 16'hFFF7);
    check("t4_V1", V1, 16'hFFFD);
    check("t4_opcode", {14'd0, opcode}, 16'd0);

    // clear mid-operation, then reset colliding with a key
    press(K_CLR); press(1); press(K_ADD); press(2); press(K_CLR);
    check("t5_V1", V1, 16'd0);
    check("t5_V2", V2, 16'd0);
    check("t5_entry", entry_value, 16'd0);
    press(K_EQ);
    check("t5_no_newop", {15'd0, newop}, 16'd0);
    press(7);
    reset = 1'b1; key_valid = 1'b1; key_code = 4'(K_EQ);
    @(negedge clock);
    reset = 1'b0; key_valid = 1'b0;
    check("t5_rst_entry", entry_value, 16'd0);
    check("t5_rst_newop", {15'd0, newop}, 16'd0);

    // operator after a result
    press(2); press(K_MUL); press(3); press(K_EQ);
    answer = 16'd6;
    press(K_ADD); press(4); press(K_EQ);
`ifdef CALC_CHAIN_EN
    check("t6_V2", V2, 16'd6);
    check("t6_V1", V1, 16'd4);
    check("t6_opcode", {14'd0, opcode}, 16'd0);
    check("t6_newop", {15'd0, newop}, 16'd1);
`else
    check("t6_entry", entry_value, 16'd4);
    check("t6_V2", V2, 16'd2);
    check("t6_V1", V1, 16'd3);
    check("t6_opcode", {14'd0, opcode}, 16'd1);
    check("t6_no_newop", {15'd0, newop}, 16'd0);
`endif

    // randomized keys against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      int k;
      answer = 16'($urandom);
      reset  = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 99);
      if (r < 50)      k = $urandom_range(0, 9);
      else if (r < 68) k = $urandom_range(10, 12);
      else if (r < 82) k = K_EQ;
      else if (r < 92) k = K_NEG;
      else             k = K_CLR;
      key_valid = ($urandom_range(0, 99) < 70);
      key_code  = 4'(k);
      @(negedge clock);
    end
    reset = 1'b0; key_valid = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
